// File: rtl/spi_xfer_ctrl_if.sv
// Command/response handshake bundle for spi_xfer_ctrl.
// req_lsb exists only when SPI_XFER_LSB_FIRST_EN is defined.
interface spi_xfer_ctrl_if #(
    parameter int SS_NUM  = 8,
    parameter int MAX_LEN = 16
);
    localparam int SS_W  = (SS_NUM > 1) ? $clog2(SS_NUM) : 1;
    localparam int LEN_W = $clog2(MAX_LEN + 1);

    logic               req_valid;
    logic               req_ready;
    logic [SS_W-1:0]    req_ss;
    logic [LEN_W-1:0]   req_len;
    logic [MAX_LEN-1:0] req_data;
`ifdef SPI_XFER_LSB_FIRST_EN
    logic               req_lsb;
`endif
    logic               resp_valid;
    logic               resp_ready;
    logic [MAX_LEN-1:0] resp_data;

`ifdef SPI_XFER_LSB_FIRST_EN
    modport master (
        output req_valid, req_ss, req_len, req_data, req_lsb, resp_ready,
        input  req_ready, resp_valid, resp_data
    );
    modport slave (
        input  req_valid, req_ss, req_len, req_data, req_lsb, resp_ready,
        output req_ready, resp_valid, resp_data
    );
`else
    modport master (
        output req_valid, req_ss, req_len, req_data, resp_ready,
        input  req_ready, resp_valid, resp_data
    );
    modport slave (
        input  req_valid, req_ss, req_len, req_data, resp_ready,
        output req_ready, resp_valid, resp_data
    );
`endif
endinterface

// File: rtl/spi_xfer_ctrl.sv
// Mode-0 SPI master: one transfer per request, MSB-first by default.
// Optional LSB-first ordering via SPI_XFER_LSB_FIRST_EN (adds bus.req_lsb).
module spi_xfer_ctrl #(
    parameter int DIV     = 4,
    parameter int SS_NUM  = 8,
    parameter int MAX_LEN = 16
) (
    input  logic              clock,
    input  logic              reset,
    spi_xfer_ctrl_if.slave    bus,
    output logic              sck,
    output logic [SS_NUM-1:0] ss,
    output logic              mosi,
    input  logic              miso
);
    localparam int LEN_W = $clog2(MAX_LEN + 1);
    localparam int HC_W  = (DIV > 1) ? $clog2(DIV) : 1;

    typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, DONE} state_t;

    state_t             state, state_n;
    logic [HC_W-1:0]    hc, hc_n;
    logic [LEN_W-1:0]   bc, bc_n, len_q, len_n;
    logic [MAX_LEN-1:0] tx_q, tx_n, rx, rx_n;
    logic               fin, fin_n;
    logic               lsb_q, lsb_n, req_lsb_in;
    logic               sck_n, mosi_n, resp_valid_q, resp_valid_n;
    logic [SS_NUM-1:0]  ss_n;
    logic               hc_last;

`ifdef SPI_XFER_LSB_FIRST_EN
    assign req_lsb_in = bus.req_lsb;
`else
    assign req_lsb_in = 1'b0;
`endif

    assign hc_last        = (hc == HC_W'(DIV - 1));
    assign bus.req_ready  = (state == IDLE) && !reset;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_data  = rx;

    // b is the count of bits still to follow the one being selected
    function automatic logic pick_bit(input logic [MAX_LEN-1:0] data,
                                      input logic [LEN_W-1:0]   len,
                                      input logic [LEN_W-1:0]   b,
                                      input logic               lsb);
        logic [LEN_W-1:0]   idx;
        logic [MAX_LEN-1:0] sh;
        idx = lsb ? (len - LEN_W'(1) - b) : b;
        sh  = data >> idx;
        return sh[0];
    endfunction

    always_comb begin
        state_n      = state;
        hc_n         = hc;
        bc_n         = bc;
        len_n        = len_q;
        tx_n         = tx_q;
        rx_n         = rx;
        fin_n        = fin;
        lsb_n        = lsb_q;
        sck_n        = sck;
        ss_n         = ss;
        mosi_n       = mosi;
        resp_valid_n = resp_valid_q;
        case (state)
            IDLE: begin
                if (bus.req_valid) begin
                    len_n = bus.req_len;
                    tx_n  = bus.req_data;
                    lsb_n = req_lsb_in;
                    rx_n  = '0;
                    if (bus.req_len == '0) begin
                        state_n      = DONE;
                        resp_valid_n = 1'b1;
                    end else begin
                        state_n = SETUP;
                        hc_n    = '0;
                        fin_n   = 1'b0;
                        bc_n    = bus.req_len - LEN_W'(1);
                        mosi_n  = pick_bit(bus.req_data, bus.req_len,
                                           bus.req_len - LEN_W'(1), req_lsb_in);
                        ss_n    = '1;
                        if (int'(bus.req_ss) < SS_NUM)
                            ss_n[bus.req_ss] = 1'b0;
                    end
                end
            end
            SETUP: begin
                hc_n = hc + HC_W'(1);
                if (hc_last) begin
                    hc_n    = '0;
                    sck_n   = 1'b1;
                    state_n = HIGH;
                end
            end
            HIGH: begin
                hc_n = hc + HC_W'(1);
                if (hc_last) begin
                    hc_n    = '0;
                    sck_n   = 1'b0;
                    state_n = LOW;
                    if (lsb_q)
                        rx_n = rx | (MAX_LEN'(miso) << (len_q - LEN_W'(1) - bc));
                    else
                        rx_n = {rx[MAX_LEN-2:0], miso};
                    if (bc == '0) begin
                        fin_n = 1'b1;
                    end else begin
                        bc_n   = bc - LEN_W'(1);
                        mosi_n = pick_bit(tx_q, len_q, bc - LEN_W'(1), lsb_q);
                    end
                end
            end
            LOW: begin
                hc_n = hc + HC_W'(1);
                if (hc_last) begin
                    hc_n = '0;
                    if (fin) begin
                        state_n      = DONE;
                        ss_n         = '1;
                        resp_valid_n = 1'b1;
                    end else begin
                        sck_n   = 1'b1;
                        state_n = HIGH;
                    end
                end
            end
            DONE: begin
                if (bus.resp_ready) begin
                    state_n      = IDLE;
                    resp_valid_n = 1'b0;
                    mosi_n       = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            hc           <= '0;
            bc           <= '0;
            len_q        <= '0;
            tx_q         <= '0;
            rx           <= '0;
            fin          <= 1'b0;
            lsb_q        <= 1'b0;
            sck          <= 1'b0;
            ss           <= '1;
            mosi         <= 1'b1;
            resp_valid_q <= 1'b0;
        end else begin
            state        <= state_n;
            hc           <= hc_n;
            bc           <= bc_n;
            len_q        <= len_n;
            tx_q         <= tx_n;
            rx           <= rx_n;
            fin          <= fin_n;
            lsb_q        <= lsb_n;
            sck          <= sck_n;
            ss           <= ss_n;
            mosi         <= mosi_n;
            resp_valid_q <= resp_valid_n;
        end
    end
endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Randomized self-checking bench for spi_xfer_ctrl against a bit-order model.
// Exercises req_lsb when SPI_XFER_LSB_FIRST_EN is defined.
module tb_spi_xfer_ctrl;
    localparam int DIV     = 4;
    localparam int SS_NUM  = 8;
    localparam int MAX_LEN = 16;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        sck, mosi, miso;
    logic [7:0]  ss;
    logic        miso_drv = 1'b0;
    logic        loopback = 1'b0;

    int          checks = 0;
    int          errors = 0;

    int          rises = 0;
    int          ss_bad = 0;
    int          ss_low = 0;
    logic        prev_sck = 1'b0;
    logic [15:0] mosi_word = '0;
    logic [15:0] mbits = '0;
    logic [7:0]  exp_ss = 8'hFF;

    spi_xfer_ctrl_if #(.SS_NUM(SS_NUM), .MAX_LEN(MAX_LEN)) bus ();

    spi_xfer_ctrl #(.DIV(DIV), .SS_NUM(SS_NUM), .MAX_LEN(MAX_LEN)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus),
        .sck   (sck),
        .ss    (ss),
        .mosi  (mosi),
        .miso  (miso)
    );

    assign miso = loopback ? mosi : miso_drv;

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL timeout global run limit exceeded");
        $fatal(1, "global timeout");
    end

    // Observe the SPI pins just after each clock edge
    always @(posedge clock) begin
        #1;
        if (sck && !prev_sck) begin
            if (ss !== exp_ss) ss_bad++;
            mosi_word = {mosi_word[14:0], mosi};
            if (rises < 16) miso_drv = mbits[rises];
            rises++;
        end
        if (ss !== 8'hFF) ss_low++;
        prev_sck = sck;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic do_xfer(input int ssi, input int len, input logic [15:0] data,
                           input bit lsb, input bit loop, input logic [15:0] mb,
                           input int stall);
        logic [15:0] exp_mosi, exp_rx, held;
        int          lat, n;
        bit          b, okv, okd, okr;

        exp_mosi = '0;
        exp_rx   = '0;
        for (int k = 0; k < len; k++) begin
            b = lsb ? data[k] : data[len-1-k];
            exp_mosi[len-1-k] = b;
            if (!loop) b = mb[k];
            if (lsb) exp_rx[k] = b;
            else     exp_rx[len-1-k] = b;
        end

        n = 0;
        while (!bus.req_ready && n < 100) begin
            @(negedge clock);
            n++;
        end
        check("req_ready_idle", {31'b0, bus.req_ready}, 32'd1);

        mbits     = mb;
        loopback  = loop;
        exp_ss    = ~(8'd1 << ssi);
        rises     = 0;
        ss_bad    = 0;
        ss_low    = 0;
        mosi_word = '0;
        bus.req_valid = 1'b1;
        bus.req_ss    = 3'(ssi);
        bus.req_len   = 5'(len);
        bus.req_data  = data;
`ifdef SPI_XFER_LSB_FIRST_EN
        bus.req_lsb   = lsb;
`endif
        @(negedge clock);
        bus.req_valid = 1'b0;
        bus.req_ss    = 3'($urandom);
        bus.req_len   = 5'($urandom);
        bus.req_data  = 16'($urandom);

        lat = 0;
        while (!bus.resp_valid && lat < 1000) begin
            @(negedge clock);
            lat++;
        end
        check("latency", 32'(lat), (len == 0) ? 32'd0 : 32'(DIV * (2 * len + 1)));
        check("ss_done", {24'b0, ss}, 32'h0000_00FF);
        check("sck_rises", 32'(rises), 32'(len));
        check("ss_select", 32'(ss_bad), 32'd0);
        check("ss_active_cycles", 32'(ss_low), (len == 0) ? 32'd0 : 32'(DIV * (2 * len + 1)));
        check("mosi_seq", {16'b0, mosi_word & ((32'd1 << len) - 1)}, {16'b0, exp_mosi});
        check("resp_data", {16'b0, bus.resp_data}, {16'b0, exp_rx});

        held = bus.resp_data;
        okv = 1; okd = 1; okr = 1;
        for (int i = 0; i < stall; i++) begin
            @(negedge clock);
            if (!bus.resp_valid) okv = 0;
            if (bus.resp_data !== held) okd = 0;
            if (bus.req_ready) okr = 0;
        end
        check("stall_valid", {31'b0, okv}, 32'd1);
        check("stall_data", {31'b0, okd}, 32'd1);
        check("stall_no_ready", {31'b0, okr}, 32'd1);

        bus.resp_ready = 1'b1;
        @(negedge clock);
        bus.resp_ready = 1'b0;
        check("resp_valid_drop", {31'b0, bus.resp_valid}, 32'd0);
        check("req_ready_back", {31'b0, bus.req_ready}, 32'd1);
        check("mosi_idle", {31'b0, mosi}, 32'd1);
    endtask

    task automatic reset_mid_xfer();
        int n, rv;
        mbits     = '0;
        loopback  = 1'b1;
        exp_ss    = ~(8'd1 << 5);
        rises     = 0;
        bus.req_valid = 1'b1;
        bus.req_ss    = 3'd5;
        bus.req_len   = 5'd12;
        bus.req_data  = 16'($urandom);
`ifdef SPI_XFER_LSB_FIRST_EN
        bus.req_lsb   = 1'b0;
`endif
        @(negedge clock);
        bus.req_valid = 1'b0;
        n = 0;
        while (rises < 3 && n < 500) begin
            @(negedge clock);
            n++;
        end
        check("rst_reach_3rd_rise", 32'(rises), 32'd3);
        reset = 1'b1;
        #1;
        check("rst_req_ready", {31'b0, bus.req_ready}, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        check("rst_sck", {31'b0, sck}, 32'd0);
        check("rst_ss", {24'b0, ss}, 32'h0000_00FF);
        check("rst_mosi", {31'b0, mosi}, 32'd1);
        check("rst_resp_valid", {31'b0, bus.resp_valid}, 32'd0);
        rises = 0;
        rv = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clock);
            if (bus.resp_valid) rv++;
        end
        check("rst_no_resp", 32'(rv), 32'd0);
        check("rst_no_sck", 32'(rises), 32'd0);
    endtask

    initial begin
        int len, ssi, stall;
        bit lsb, loop;

        bus.req_valid  = 1'b0;
        bus.req_ss     = '0;
        bus.req_len    = '0;
        bus.req_data   = '0;
        bus.resp_ready = 1'b0;
`ifdef SPI_XFER_LSB_FIRST_EN
        bus.req_lsb    = 1'b0;
`endif
        repeat (3) @(negedge clock);
        check("reset_req_ready", {31'b0, bus.req_ready}, 32'd0);
        reset = 1'b0;
        @(negedge clock);
        check("reset_sck", {31'b0, sck}, 32'd0);
        check("reset_ss", {24'b0, ss}, 32'h0000_00FF);
        check("reset_mosi", {31'b0, mosi}, 32'd1);
        check("reset_resp_valid", {31'b0, bus.resp_valid}, 32'd0);
        check("reset_resp_data", {16'b0, bus.resp_data}, 32'd0);
        check("reset_idle_ready", {31'b0, bus.req_ready}, 32'd1);

        // Directed cases
        do_xfer(2, 8, 16'h00A5, 1'b0, 1'b1, 16'h0000, 10);
        do_xfer(0, 16, 16'h0000, 1'b0, 1'b0, 16'hFFFF, 0);
        do_xfer(7, 0, 16'hBEEF, 1'b0, 1'b0, 16'hFFFF, 2);
        do_xfer(3, 1, 16'h0001, 1'b0, 1'b0, 16'h0000, 0);
`ifdef SPI_XFER_LSB_FIRST_EN
        do_xfer(1, 4, 16'h000B, 1'b1, 1'b1, 16'h0000, 0);
`endif

        for (int t = 0; t < 30; t++) begin
            ssi   = int'($urandom_range(0, 7));
            len   = int'($urandom_range(0, 16));
            loop  = 1'($urandom);
            stall = int'($urandom_range(0, 3));
`ifdef SPI_XFER_LSB_FIRST_EN
            lsb   = 1'($urandom);
`else
            lsb   = 1'b0;
`endif
            do_xfer(ssi, len, 16'($urandom), lsb, loop, 16'($urandom), stall);
        end

        reset_mid_xfer();
        do_xfer(4, 5, 16'h0013, 1'b0, 1'b0, 16'($urandom), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
